// File: rtl/accel_pkg.sv
// Shared definitions for the accelerometer sample path: assembler states,
// sample widths and the ADXL345 data register address.
package accel_pkg;

    // Byte-pair assembler states
    typedef enum logic {
        WAIT_LO = 1'b0,
        WAIT_HI = 1'b1
    } asm_state_t;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned RAW10_W  = 10;

    // First axis data register of the ADXL345, also used by the SPI master
    localparam logic [7:0] ADXL_DATAX0 = 8'h32;

endpackage

// File: rtl/sample_fifo_mem.sv
// DEPTH x SAMPLE_W register array: synchronous write port, registered read
// port. A read and write to the same address in one cycle returns old data.
module sample_fifo_mem
    import accel_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    output logic [SAMPLE_W-1:0] rd_data
);

    logic [SAMPLE_W-1:0] mem [DEPTH];

    // Write port: storage is not reset, only the read register is
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Registered read port; holds its value between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/accel_sample_fifo.sv
// Pairs LSB/MSB bytes from the ADXL345 SPI master into signed 16-bit
// samples and buffers them in a synchronous FIFO drained by read_req.
// Optional feature: define ACCEL_FIFO_OVF_CNT_EN to build the saturating
// dropped-sample counter on ovf_count; otherwise ovf_count reads zero.
module accel_sample_fifo
    import accel_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_byte,
    input  logic                rx_valid,
    input  logic                rx_first,
    input  logic                ten_bit,
    input  logic                read_req,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                empty,
    output logic                full,
    output logic [AW:0]         count,
    output logic                overflow,
    output logic [7:0]          ovf_count
);

    asm_state_t          state;
    logic [7:0]          lo;
    logic [SAMPLE_W-1:0] formed;
    logic                push;
    logic [SAMPLE_W-1:0] push_data;

    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                pop;
    logic                do_write;
    logic                drop;
    logic [AW:0]         count_next;

    // Sample formation from the latched LSB and the incoming MSB
    always_comb begin
        formed = {rx_byte, lo};
        if (ten_bit)
            formed = {{(SAMPLE_W - RAW10_W){rx_byte[1]}}, rx_byte[1:0], lo};
    end

    // Assembler FSM; the push request and its data are registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= WAIT_LO;
            lo        <= '0;
            push      <= 1'b0;
            push_data <= '0;
        end else begin
            push <= 1'b0;
            if (rx_valid && rx_first) begin
                lo    <= rx_byte;
                state <= WAIT_HI;
            end else if (rx_valid && state == WAIT_HI) begin
                push      <= 1'b1;
                push_data <= formed;
                state     <= WAIT_LO;
            end
        end
    end

    // Pop needs stored data, so a push into an empty FIFO never falls through;
    // when full, a coincident pop frees the slot the push writes into.
    always_comb begin
        pop        = read_req && !empty;
        do_write   = push && (!full || pop);
        drop       = push && full && !pop;
        count_next = count + {{AW{1'b0}}, do_write} - {{AW{1'b0}}, pop};
    end

    // Pointers, occupancy and registered flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            sample_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (do_write)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == (AW+1)'(DEPTH));
            sample_valid <= pop;
            if (drop)
                overflow <= 1'b1;
        end
    end

`ifdef ACCEL_FIFO_OVF_CNT_EN
    // Saturating count of dropped samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf_count <= '0;
        else if (drop && ovf_count != 8'hFF)
            ovf_count <= ovf_count + 8'd1;
    end
`else
    assign ovf_count = '0;
`endif

    sample_fifo_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (do_write),
        .wr_addr(wr_ptr),
        .wr_data(push_data),
        .rd_en  (pop),
        .rd_addr(rd_ptr),
        .rd_data(sample_out)
    );

endmodule

// File: tb/tb_accel_sample_fifo.sv
// Directed bench for accel_sample_fifo with a sample scoreboard.
module tb_accel_sample_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_first;
    logic        ten_bit;
    logic        read_req;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  ovf_count;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] sb [$];

`ifdef ACCEL_FIFO_OVF_CNT_EN
    localparam logic [7:0] OVF1 = 8'd1;
`else
    localparam logic [7:0] OVF1 = 8'd0;
`endif

    always #5 clk = ~clk;

    accel_sample_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_first    (rx_first),
        .ten_bit     (ten_bit),
        .read_req    (read_req),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overflow    (overflow),
        .ovf_count   (ovf_count)
    );

    function automatic logic [15:0] model(input logic [7:0] l, input logic [7:0] h, input logic tb);
        logic [9:0] raw;
        raw = {h[1:0], l};
        if (tb)
            return (raw[9]) ? (16'hFC00 | 16'(raw)) : 16'(raw);
        return {h, l};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".sample_out"}, 32'(sample_out), 32'h0);
        chk({tag, ".sample_valid"}, 32'(sample_valid), 32'h0);
        chk({tag, ".empty"}, 32'(empty), 32'h1);
        chk({tag, ".full"}, 32'(full), 32'h0);
        chk({tag, ".count"}, 32'(count), 32'h0);
        chk({tag, ".overflow"}, 32'(overflow), 32'h0);
        chk({tag, ".ovf_count"}, 32'(ovf_count), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        sb.delete();
        chk_reset_state("reset");
        reset = 1'b0;
    endtask

    // LSB then MSB, returns one negedge after the count update
    task automatic send_pair(input logic [7:0] l, input logic [7:0] h, input logic expect_push);
        @(negedge clk);
        rx_valid = 1'b1; rx_first = 1'b1; rx_byte = l;
        @(negedge clk);
        rx_first = 1'b0; rx_byte = h;
        @(negedge clk);
        rx_valid = 1'b0;
        if (expect_push) sb.push_back(model(l, h, ten_bit));
        @(negedge clk);
    endtask

    task automatic do_read(input string tag);
        logic [15:0] exp;
        @(negedge clk);
        read_req = 1'b1;
        @(negedge clk);
        read_req = 1'b0;
        chk({tag, ".valid"}, 32'(sample_valid), 32'h1);
        if (sb.size() == 0) begin
            chk({tag, ".sb_nonempty"}, 32'h0, 32'h1);
        end else begin
            exp = sb.pop_front();
            chk({tag, ".data"}, 32'(sample_out), 32'(exp));
        end
        @(negedge clk);
        chk({tag, ".valid_drop"}, 32'(sample_valid), 32'h0);
    endtask

    initial begin
        logic [15:0] exp;
        logic [15:0] held;
        reset = 1'b1; rx_byte = '0; rx_valid = 1'b0; rx_first = 1'b0;
        ten_bit = 1'b0; read_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("por");
        reset = 1'b0;

        // 1: basic pair, 16-bit format
        send_pair(8'h34, 8'h12, 1'b1);
        chk("t1.count", 32'(count), 32'd1);
        chk("t1.empty", 32'(empty), 32'd0);
        do_read("t1.read");
        chk("t1.value", 32'(sample_out), 32'h1234);
        chk("t1.empty_after", 32'(empty), 32'd1);

        // Read on empty: no pulse, output held
        held = sample_out;
        @(negedge clk); read_req = 1'b1;
        @(negedge clk); read_req = 1'b0;
        chk("t1.empty_read_valid", 32'(sample_valid), 32'h0);
        chk("t1.empty_read_hold", 32'(sample_out), 32'(held));

        // 2: 10-bit sign extension
        ten_bit = 1'b1;
        send_pair(8'hFF, 8'h03, 1'b1);
        send_pair(8'h00, 8'h02, 1'b1);
        send_pair(8'h55, 8'h01, 1'b1);
        do_read("t2.r0");
        chk("t2.ffff", 32'(sample_out), 32'hFFFF);
        do_read("t2.r1");
        chk("t2.fe00", 32'(sample_out), 32'hFE00);
        do_read("t2.r2");
        ten_bit = 1'b0;

        // 3: fill, overflow, drain
        for (int i = 0; i < 16; i++)
            send_pair(8'(i), 8'(8'hA0 + i), 1'b1);
        chk("t3.full", 32'(full), 32'd1);
        chk("t3.count16", 32'(count), 32'd16);
        chk("t3.ovf_pre", 32'(overflow), 32'd0);
        send_pair(8'hEE, 8'hEE, 1'b0);
        chk("t3.overflow", 32'(overflow), 32'd1);
        chk("t3.ovf_count", 32'(ovf_count), 32'(OVF1));
        chk("t3.count_hold", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++)
            do_read("t3.drain");
        chk("t3.empty", 32'(empty), 32'd1);
        chk("t3.count0", 32'(count), 32'd0);
        chk("t3.overflow_sticky", 32'(overflow), 32'd1);

        // 4: coincident push and pop when full, then when empty
        do_reset();
        for (int i = 0; i < 16; i++)
            send_pair(8'(8'h10 + i), 8'(8'h70 + i), 1'b1);
        @(negedge clk);
        rx_valid = 1'b1; rx_first = 1'b1; rx_byte = 8'hC1;
        @(negedge clk);
        rx_first = 1'b0; rx_byte = 8'h5C;
        @(negedge clk);
        rx_valid = 1'b0; read_req = 1'b1;
        @(negedge clk);
        read_req = 1'b0;
        exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        sb.push_back(16'h5CC1);
        chk("t4.full_valid", 32'(sample_valid), 32'd1);
        chk("t4.full_data", 32'(sample_out), 32'(exp));
        chk("t4.full_count", 32'(count), 32'd16);
        chk("t4.full_nodrop", 32'(overflow), 32'd0);
        chk("t4.full_ovfcnt", 32'(ovf_count), 32'd0);
        for (int i = 0; i < 16; i++)
            do_read("t4.drain");
        chk("t4.drained", 32'(empty), 32'd1);

        @(negedge clk);
        rx_valid = 1'b1; rx_first = 1'b1; rx_byte = 8'h22;
        @(negedge clk);
        rx_first = 1'b0; rx_byte = 8'h11;
        @(negedge clk);
        rx_valid = 1'b0; read_req = 1'b1;
        sb.push_back(16'h1122);
        @(negedge clk);
        read_req = 1'b0;
        chk("t4.empty_novalid", 32'(sample_valid), 32'd0);
        chk("t4.empty_count", 32'(count), 32'd1);
        do_read("t4.empty_read");

        // 5: stray MSB and LSB resync
        @(negedge clk);
        rx_valid = 1'b1; rx_first = 1'b0; rx_byte = 8'h99;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5.stray_count", 32'(count), 32'd0);
        @(negedge clk);
        rx_valid = 1'b1; rx_first = 1'b1; rx_byte = 8'hAA;
        @(negedge clk);
        rx_byte = 8'hBB;
        @(negedge clk);
        rx_first = 1'b0; rx_byte = 8'h44;
        @(negedge clk);
        rx_valid = 1'b0;
        sb.push_back(16'h44BB);
        @(negedge clk);
        chk("t5.resync_count", 32'(count), 32'd1);
        do_read("t5.resync");

        // 6: reset with 5 entries and a pair in flight
        for (int i = 0; i < 5; i++)
            send_pair(8'(8'h30 + i), 8'(8'h60 + i), 1'b1);
        chk("t6.count5", 32'(count), 32'd5);
        @(negedge clk);
        rx_valid = 1'b1; rx_first = 1'b1; rx_byte = 8'hDD;
        @(negedge clk);
        rx_valid = 1'b0;
        do_reset();
        // Leftover MSB must be discarded as stray after reset
        @(negedge clk);
        rx_valid = 1'b1; rx_first = 1'b0; rx_byte = 8'h77;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6.no_stale_push", 32'(count), 32'd0);
        send_pair(8'h78, 8'h56, 1'b1);
        chk("t6.count1", 32'(count), 32'd1);
        do_read("t6.read");
        chk("t6.value", 32'(sample_out), 32'h5678);
        chk("t6.sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
